// File: rtl/poly_inside_check.sv
// poly_inside_check: tests whether a point lies inside a pre-sorted convex polygon
// by checking the sign of the cross product for each edge, one edge per cycle.
// Latency: eff_n+1 cycles from start to valid, or 1 cycle when fewer than 3 vertices.
// Backpressure: none; start is sampled only in IDLE, and requests arriving while busy are dropped.
// Ports: clk/reset (sync, active-high); start, obj, verts, num_v, orient, incl_edge in;
//        busy, valid (one-cycle pulse), is_inside (held between results) out.
module poly_inside_check #(
    parameter int CW = 10,
    parameter int NV = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [2*CW-1:0]           obj,
    input  logic [NV*2*CW-1:0]        verts,
    input  logic [$clog2(NV+1)-1:0]   num_v,
    input  logic                      orient,
    input  logic                      incl_edge,
    output logic                      busy,
    output logic                      valid,
    output logic                      is_inside
);
    localparam int NW = $clog2(NV+1);
    localparam int TW = 2*CW + 3;

    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    state_t             state;
    logic [NW-1:0]      k;
    logic [NW-1:0]      n_q;
    logic [NW-1:0]      eff_n;
    logic [NW-1:0]      k_next;
    logic               last_edge;
    logic [CW-1:0]      px_q;
    logic [CW-1:0]      py_q;
    logic [CW-1:0]      vx_q [NV];
    logic [CW-1:0]      vy_q [NV];
    logic               orient_q;
    logic               incl_q;
    logic               all_ok;

    logic [CW-1:0]      vkx;
    logic [CW-1:0]      vky;
    logic [CW-1:0]      vnx;
    logic [CW-1:0]      vny;
    logic signed [CW:0] ax;
    logic signed [CW:0] ay;
    logic signed [CW:0] bx;
    logic signed [CW:0] by;
    logic signed [TW-1:0] term;
    logic               term_pos;
    logic               term_neg;
    logic               term_zero;
    logic               pass;

    // Vertex counts above NV saturate to NV.
    assign eff_n     = (num_v > NW'(NV)) ? NW'(NV) : num_v;
    assign last_edge = (k == n_q - NW'(1));
    // The final edge wraps back to vertex 0 to close the polygon.
    assign k_next    = last_edge ? '0 : k + NW'(1);

    always_comb begin
        vkx = '0;
        vky = '0;
        vnx = '0;
        vny = '0;
        for (int i = 0; i < NV; i++) begin
            if (k == NW'(i)) begin
                vkx = vx_q[i];
                vky = vy_q[i];
            end
            if (k_next == NW'(i)) begin
                vnx = vx_q[i];
                vny = vy_q[i];
            end
        end
    end

    // Zero-extended differences fit exactly in CW+1 signed bits.
    assign ax = $signed({1'b0, vkx}) - $signed({1'b0, px_q});
    assign ay = $signed({1'b0, vky}) - $signed({1'b0, py_q});
    assign bx = $signed({1'b0, vnx}) - $signed({1'b0, vkx});
    assign by = $signed({1'b0, vny}) - $signed({1'b0, vky});

    // Each product needs 2CW+2 bits; the difference needs one more.
    assign term      = TW'(ax) * TW'(by) - TW'(ay) * TW'(bx);
    assign term_neg  = term[TW-1];
    assign term_zero = ~|term;
    assign term_pos  = ~term_neg & ~term_zero;
    assign pass      = (orient_q & term_pos) | (~orient_q & term_neg) | (term_zero & incl_q);

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            k         <= '0;
            all_ok    <= 1'b0;
            valid     <= 1'b0;
            is_inside <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    if (start) begin
                        px_q     <= obj[2*CW-1:CW];
                        py_q     <= obj[CW-1:0];
                        for (int i = 0; i < NV; i++) begin
                            vx_q[i] <= verts[i*2*CW + CW +: CW];
                            vy_q[i] <= verts[i*2*CW +: CW];
                        end
                        n_q      <= eff_n;
                        orient_q <= orient;
                        incl_q   <= incl_edge;
                        k        <= '0;
                        all_ok   <= 1'b1;
                        if (eff_n < NW'(3)) begin
                            // Degenerate polygon: report outside immediately.
                            state     <= DONE;
                            valid     <= 1'b1;
                            is_inside <= 1'b0;
                        end else begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    // A failing edge does not end the scan early; latency stays fixed.
                    all_ok <= all_ok & pass;
                    if (last_edge) begin
                        state     <= DONE;
                        valid     <= 1'b1;
                        is_inside <= all_ok & pass;
                        k         <= '0;
                    end else begin
                        k <= k + NW'(1);
                    end
                end
                DONE: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_poly_inside_check.sv
module tb_poly_inside_check;
    localparam int CW = 10;
    localparam int NV = 8;
    localparam int NW = $clog2(NV+1);

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [2*CW-1:0]       obj;
    logic [NV*2*CW-1:0]    verts;
    logic [NW-1:0]         num_v;
    logic                  orient;
    logic                  incl_edge;
    logic                  busy;
    logic                  valid;
    logic                  is_inside;

    int n_checks = 0;
    int n_fail   = 0;
    int vx [NV];
    int vy [NV];

    poly_inside_check #(.CW(CW), .NV(NV)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .obj       (obj),
        .verts     (verts),
        .num_v     (num_v),
        .orient    (orient),
        .incl_edge (incl_edge),
        .busy      (busy),
        .valid     (valid),
        .is_inside (is_inside)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
        end
    endtask

    // Reference: every edge's cross-product sign must match the orientation rule.
    function automatic bit ref_inside(input int px, input int py, input int n,
                                      input bit ori, input bit inc);
        int eff;
        int nx;
        int ax, ay, bx, by, t;
        bit ok;
        eff = (n > NV) ? NV : n;
        if (eff < 3) return 1'b0;
        ok = 1'b1;
        for (int kk = 0; kk < eff; kk++) begin
            nx = (kk + 1) % eff;
            ax = vx[kk] - px;
            ay = vy[kk] - py;
            bx = vx[nx] - vx[kk];
            by = vy[nx] - vy[kk];
            t  = ax * by - ay * bx;
            if (!((ori && t > 0) || (!ori && t < 0) || (t == 0 && inc))) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic pack_verts();
        for (int i = 0; i < NV; i++) begin
            verts[i*2*CW + CW +: CW] = CW'(vx[i]);
            verts[i*2*CW +: CW]      = CW'(vy[i]);
        end
    endtask

    task automatic load_square(input int s);
        for (int i = 0; i < NV; i++) begin
            vx[i] = 0;
            vy[i] = 0;
        end
        vx[1] = s; vy[1] = 0;
        vx[2] = s; vy[2] = s;
        vx[3] = 0; vy[3] = s;
    endtask

    // Issues one request, scrambles the inputs after acceptance, then checks
    // busy, latency, result and the single-cycle valid pulse.
    task automatic run_req(input string tag, input int px, input int py, input int n,
                           input bit ori, input bit inc, input bit repulse);
        int eff, exp_lat, cyc;
        bit exp_in;
        eff     = (n > NV) ? NV : n;
        exp_lat = (eff < 3) ? 1 : eff + 1;
        exp_in  = ref_inside(px, py, n, ori, inc);
        obj       = {CW'(px), CW'(py)};
        pack_verts();
        num_v     = NW'(n);
        orient    = ori;
        incl_edge = inc;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        obj       = (2*CW)'($urandom);
        for (int i = 0; i < NV*2; i++) verts[i*CW +: CW] = CW'($urandom);
        num_v     = NW'($urandom);
        orient    = ~ori;
        incl_edge = ~inc;
        cyc = 1;
        while (valid !== 1'b1 && cyc < 40) begin
            check({tag, "_busy"}, busy, 1);
            start = (repulse && cyc == 1) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_inside"}, is_inside, exp_in);
        check({tag, "_busy_done"}, busy, 1);
        @(posedge clk); #1;
        check({tag, "_valid_drop"}, valid, 0);
        check({tag, "_busy_idle"}, busy, 0);
        check({tag, "_inside_hold"}, is_inside, exp_in);
        if (repulse) begin
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1;
                check({tag, "_no_second_valid"}, valid, 0);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; obj = '0; verts = '0; num_v = '0;
        orient = 1'b1; incl_edge = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", valid, 0);
        check("reset_busy", busy, 0);
        check("reset_inside", is_inside, 0);
        reset = 1'b0;

        // Directed cases on the 10x10 square.
        load_square(10);
        run_req("sq_center", 5, 5, 4, 1'b1, 1'b0, 1'b0);
        run_req("sq_outside", 15, 5, 4, 1'b1, 1'b0, 1'b0);
        run_req("sq_edge_incl", 10, 5, 4, 1'b1, 1'b1, 1'b0);
        run_req("sq_edge_excl", 10, 5, 4, 1'b1, 1'b0, 1'b0);
        run_req("sq_wrong_orient", 5, 5, 4, 1'b0, 1'b0, 1'b0);
        run_req("two_verts", 5, 5, 2, 1'b1, 1'b0, 1'b0);
        run_req("zero_verts", 5, 5, 0, 1'b1, 1'b1, 1'b0);
        run_req("num_v_9", 5, 5, 9, 1'b1, 1'b1, 1'b0);
        run_req("repulse", 5, 5, 4, 1'b1, 1'b0, 1'b1);

        // Reset mid-CHECK aborts without a valid.
        obj = {CW'(5), CW'(5)};
        pack_verts();
        num_v = NW'(4); orient = 1'b1; incl_edge = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("abort_busy", busy, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_valid", valid, 0);
        check("abort_busy_cleared", busy, 0);
        check("abort_inside_cleared", is_inside, 0);
        @(posedge clk); #1;
        check("abort_idle_valid", valid, 0);
        run_req("after_abort", 5, 5, 4, 1'b1, 1'b0, 1'b0);

        // Full-scale coordinates.
        load_square(1023);
        run_req("full_inside", 1, 1022, 4, 1'b1, 1'b0, 1'b0);
        run_req("full_corner_incl", 1023, 1023, 4, 1'b1, 1'b1, 1'b0);
        run_req("full_corner_excl", 1023, 1023, 4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < NV; i++) begin
            vx[i] = 0; vy[i] = 0;
        end
        vx[0] = 1023; vy[0] = 0;
        vx[1] = 0;    vy[1] = 1023;
        vx[2] = 1023; vy[2] = 1023;
        run_req("full_cw_tri", 1000, 1000, 3, 1'b0, 1'b0, 1'b0);

        // Random polygons: small grids hit zero terms, full range stresses width.
        for (int it = 0; it < 80; it++) begin
            int lim;
            lim = (it % 2 == 0) ? 15 : 1023;
            for (int i = 0; i < NV; i++) begin
                vx[i] = $urandom_range(lim, 0);
                vy[i] = $urandom_range(lim, 0);
            end
            if (it % 4 == 1) begin
                load_square(lim);
            end
            run_req("random", $urandom_range(lim, 0), $urandom_range(lim, 0),
                    $urandom_range(10, 0), 1'($urandom), 1'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
